// File: rtl/button_event_controller.sv
// AHB-Lite button event controller: debounces active-low buttons and latches click/double/long/chord events.
// Latency: 2 sync + DEBOUNCE_CYCLES to a debounced edge; bus reads and writes have zero wait states.
// Backpressure: none; HREADYOUT is tied high and events are sticky until software clears them (W1C).
// Optional IRQ output is enabled by defining BUTTON_EVENT_IRQ_EN.
module button_event_controller #(
  parameter int NUM_BUTTONS         = 2,
  parameter int DEBOUNCE_CYCLES     = 900,
  parameter int CLICK_WINDOW_CYCLES = 16000,
  parameter int LONG_PRESS_CYCLES   = 32000
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [31:0]            HADDR,
  input  logic [31:0]            HWDATA,
  input  logic                   HWRITE,
  input  logic                   HREADY,
  input  logic                   HSEL,
  input  logic [2:0]             HSIZE,
  input  logic [1:0]             HTRANS,
  input  logic [NUM_BUTTONS-1:0] Buttons,
  output logic [31:0]            HRDATA,
  output logic                   HREADYOUT,
  output logic                   IRQ
);

  localparam int MAX_A = (DEBOUNCE_CYCLES > CLICK_WINDOW_CYCLES) ? DEBOUNCE_CYCLES : CLICK_WINDOW_CYCLES;
  localparam int MAX_C = (MAX_A > LONG_PRESS_CYCLES) ? MAX_A : LONG_PRESS_CYCLES;
  localparam int CW    = $clog2(MAX_C) + 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LIM = CW'(LONG_PRESS_CYCLES);
  localparam logic [CW-1:0] WIN_LIM  = CW'(CLICK_WINDOW_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_WAIT2, ST_HELD} state_t;

  logic [NUM_BUTTONS-1:0] r_sync1, r_sync2, r_level;
  logic [CW-1:0]          r_dcnt [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] w_sync_prs, w_flip, w_press, w_release, w_chord;
  state_t                 r_state [NUM_BUTTONS];
  state_t                 w_state_nxt [NUM_BUTTONS];
  logic [CW-1:0]          r_cnt [NUM_BUTTONS];
  logic [CW-1:0]          w_cnt_nxt [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] w_set_single, w_set_double, w_set_long;
  logic [NUM_BUTTONS-1:0] r_single, r_double, r_long, r_chord;
  logic [NUM_BUTTONS-1:0] w_clr_single, w_clr_double, w_clr_long, w_clr_chord;
  logic [NUM_BUTTONS-1:0] w_irq_mask;
  logic                   r_dp_vld, r_dp_wr;
  logic [2:0]             r_dp_off;
  logic                   w_wr_en;
  logic                   w_unused_bits;

  assign HREADYOUT     = 1'b1;
  assign w_unused_bits = ^{HSIZE, HADDR[31:5], HADDR[1:0], HWDATA};
  assign w_sync_prs    = ~r_sync2;

  // Two-flop synchroniser; released (1) is the idle level
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= Buttons;
      r_sync2 <= r_sync1;
    end
  end

  // Debounced edge detect: level flips on the DEBOUNCE_CYCLES-th consecutive differing cycle
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      w_flip[i] = (w_sync_prs[i] != r_level[i]) && (r_dcnt[i] == DEB_LAST);
    end
  end

  assign w_press   = w_flip & w_sync_prs;
  assign w_release = w_flip & ~w_sync_prs;

  // Debounce counter and debounced level (1 = pressed)
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_level <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) r_dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (w_sync_prs[i] == r_level[i]) begin
          r_dcnt[i] <= '0;
        end else if (w_flip[i]) begin
          r_level[i] <= ~r_level[i];
          r_dcnt[i]  <= '0;
        end else if (r_dcnt[i] != '1) begin
          r_dcnt[i] <= r_dcnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Chord: a new press while another button is held or also being pressed
  always_comb begin
    w_chord = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      w_chord[i] = (w_press[i] && |((r_level | w_press) & ~(NUM_BUTTONS'(1) << i))) ||
                   (r_level[i] && |(w_press & ~(NUM_BUTTONS'(1) << i)));
    end
  end

  // Per-button FSM state and shared hold/window counter
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  // Next-state: chord overrides everything; a chord participant releasing returns to IDLE
  always_comb begin
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      if (w_chord[i]) begin
        w_state_nxt[i] = w_release[i] ? ST_IDLE : ST_HELD;
      end else begin
        case (r_state[i])
          ST_IDLE: if (w_press[i]) begin
            w_state_nxt[i] = ST_PRESSED;
            w_cnt_nxt[i]   = CNT_ONE;
          end
          ST_PRESSED: if (w_release[i]) begin
            w_state_nxt[i] = ST_WAIT2;
            w_cnt_nxt[i]   = CNT_ONE;
          end else if (r_cnt[i] == LONG_LIM) begin
            w_state_nxt[i] = ST_HELD;
          end else if (r_cnt[i] != '1) begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
          end
          ST_WAIT2: if (w_press[i]) begin
            w_state_nxt[i] = ST_HELD;
          end else if (r_cnt[i] == WIN_LIM) begin
            w_state_nxt[i] = ST_IDLE;
          end else if (r_cnt[i] != '1) begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
          end
          default: if (w_release[i]) w_state_nxt[i] = ST_IDLE;
        endcase
      end
    end
  end

  // Event outputs of the FSM (single-cycle set pulses)
  always_comb begin
    w_set_single = '0;
    w_set_double = '0;
    w_set_long   = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (!w_chord[i]) begin
        if (r_state[i] == ST_PRESSED) w_set_long[i] = !w_release[i] && (r_cnt[i] == LONG_LIM);
        if (r_state[i] == ST_WAIT2) begin
          w_set_double[i] = w_press[i];
          w_set_single[i] = !w_press[i] && (r_cnt[i] == WIN_LIM);
        end
      end
    end
  end

  // Bus address phase capture
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dp_vld <= 1'b0;
      r_dp_wr  <= 1'b0;
      r_dp_off <= '0;
    end else if (HREADY) begin
      r_dp_vld <= HSEL && (HTRANS != 2'b00);
      r_dp_wr  <= HWRITE;
      r_dp_off <= HADDR[4:2];
    end
  end

  assign w_wr_en      = r_dp_vld && r_dp_wr;
  assign w_clr_single = (w_wr_en && r_dp_off == 3'd1) ? HWDATA[NUM_BUTTONS-1:0] : '0;
  assign w_clr_double = (w_wr_en && r_dp_off == 3'd2) ? HWDATA[NUM_BUTTONS-1:0] : '0;
  assign w_clr_long   = (w_wr_en && r_dp_off == 3'd3) ? HWDATA[NUM_BUTTONS-1:0] : '0;
  assign w_clr_chord  = (w_wr_en && r_dp_off == 3'd4) ? HWDATA[NUM_BUTTONS-1:0] : '0;

  // Sticky event registers; a hardware set in the same cycle beats a software clear
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_single <= '0;
      r_double <= '0;
      r_long   <= '0;
      r_chord  <= '0;
    end else begin
      r_single <= (r_single & ~w_clr_single) | w_set_single;
      r_double <= (r_double & ~w_clr_double) | w_set_double;
      r_long   <= (r_long   & ~w_clr_long)   | w_set_long;
      r_chord  <= (r_chord  & ~w_clr_chord)  | w_chord;
    end
  end

`ifdef BUTTON_EVENT_IRQ_EN
  logic [NUM_BUTTONS-1:0] r_irq_mask;
  logic                   r_irq;

  // Interrupt mask register and registered interrupt
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_irq_mask <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr_en && r_dp_off == 3'd6) r_irq_mask <= HWDATA[NUM_BUTTONS-1:0];
      r_irq <= |(r_irq_mask & (r_single | r_double | r_long | r_chord));
    end
  end

  assign w_irq_mask = r_irq_mask;
  assign IRQ        = r_irq;
`else
  assign w_irq_mask = '0;
  assign IRQ        = 1'b0;
`endif

  // Read data mux for the registered data-phase address
  always_comb begin
    HRDATA = '0;
    if (r_dp_vld && !r_dp_wr) begin
      case (r_dp_off)
        3'd0: HRDATA[0] = |{r_single, r_double, r_long, r_chord};
        3'd1: HRDATA[NUM_BUTTONS-1:0] = r_single;
        3'd2: HRDATA[NUM_BUTTONS-1:0] = r_double;
        3'd3: HRDATA[NUM_BUTTONS-1:0] = r_long;
        3'd4: HRDATA[NUM_BUTTONS-1:0] = r_chord;
        3'd5: HRDATA[NUM_BUTTONS-1:0] = r_level;
        3'd6: HRDATA[NUM_BUTTONS-1:0] = w_irq_mask;
        default: HRDATA = '0;
      endcase
    end
  end

endmodule

// File: doc/button_event_controller.md
Name: button_event_controller

Overview:
- Parametrised AHB-Lite slave debouncing NUM_BUTTONS active-low push buttons.
- Classifies each button's activity into single-click, double-click, long-press and chord events.
- Latches events in sticky write-1-to-clear registers read by the CPU over the peripheral bus.
- Successor to the fixed two-button Mode/Trip manager; software decodes meaning (mode, trip, setting, day/night) from event types.

Parameters:
NUM_BUTTONS, 2, number of button inputs (1..16)
DEBOUNCE_CYCLES, 900, consecutive stable cycles before a debounced level change is accepted
CLICK_WINDOW_CYCLES, 16000, cycles after release in which a second press forms a double-click
LONG_PRESS_CYCLES, 32000, hold cycles after debounced press that make a long press (must exceed DEBOUNCE_CYCLES)

Ports:
HCLK  in  1  system clock
HRESETn  in  1  asynchronous active-low reset
HADDR  in  32  byte address; only HADDR[4:2] decoded
HWDATA  in  32  write data (data phase)
HWRITE  in  1  transfer direction
HREADY  in  1  bus ready
HSEL  in  1  slave select
HSIZE  in  3  ignored; word access only
HTRANS  in  2  transfer type; IDLE (2'b00) ignored
Buttons  in  NUM_BUTTONS  raw button levels, 0 = pressed, asynchronous
HRDATA  out  32  read data (data phase)
HREADYOUT  out  1  constant 1, zero wait states
IRQ  out  1  interrupt request (see Optional Feature)

Behaviour:
- Clock HCLK; reset asynchronous active-low on HRESETn. All flops reset: synchronisers to 1 (released), counters 0, FSMs IDLE, event registers 0, IRQ 0, HRDATA reads 0.
- Input path: 2-flop synchroniser per button, then debouncer.
- Debouncer: counter resets whenever sync level equals debounced level; else increments. On reaching DEBOUNCE_CYCLES, debounced level flips and counter clears. Press/release pulses are 1 cycle.
- Per-button FSM:
  - IDLE: press pulse -> PRESSED, hold counter = 1.
  - PRESSED: counter reaching LONG_PRESS_CYCLES -> set LONG[i], go HELD. Release pulse -> WAIT2, window counter = 1.
  - WAIT2: press pulse -> set DOUBLE[i], go HELD. Window counter reaching CLICK_WINDOW_CYCLES -> set SINGLE[i], go IDLE.
  - HELD: release pulse -> IDLE; no further events.
- Chord: a press pulse on button i while any other button is debounced-pressed sets CHORD[i] and CHORD[j] for every such held j. All participating FSMs go HELD, suppressing single/double/long. Simultaneous press pulses on two or more buttons also form a chord.
- Counters saturate and never wrap. Width is clog2 of the largest cycle parameter plus 1.
- Register map (word offsets; event bits [NUM_BUTTONS-1:0], upper bits read 0):
  - 0 STATUS: bit0 NEWDATA = OR of all event bits; RO.
  - 1 SINGLE: W1C.
  - 2 DOUBLE: W1C.
  - 3 LONG: W1C.
  - 4 CHORD: W1C.
  - 5 LEVEL: debounced levels, 1 = pressed; RO.
  - 6 IRQ_MASK: RW.
  - 7: reads 0.
- Bus: address phase (HSEL & HREADY & HTRANS!=IDLE) registers address and write flag. Data phase drives HRDATA combinationally from the registered address, or applies HWDATA.
- Reads have no side effects. Writes to RO/unmapped offsets are ignored.
- Same-cycle hardware set and W1C of the same bit: set wins.
- Reset mid-press: everything returns to IDLE. A button still held after reset is debounced as a fresh press.

Optional Feature:
- Macro BUTTON_EVENT_IRQ_EN.
- Defined: IRQ is registered, = |(IRQ_MASK & (SINGLE|DOUBLE|LONG|CHORD)) per button bit. It updates the cycle after event or mask changes; IRQ_MASK resets to 0.
- Undefined: IRQ tied 0; IRQ_MASK reads 0 and writes are ignored.

Test Plan (NUM_BUTTONS=2, DEBOUNCE_CYCLES=4, CLICK_WINDOW_CYCLES=20, LONG_PRESS_CYCLES=50):
- Button0 pressed 10 cycles then released, idle 30 -> SINGLE=0x1, STATUS=1, DOUBLE/LONG/CHORD=0. Write 0x1 to SINGLE -> STATUS=0.
- Button1 press 10, release 8, press 10, release -> DOUBLE=0x2, SINGLE=0 after 30 more cycles.
- Button0 held 80 cycles -> LONG=0x1 about 56 cycles after press edge (2 sync + 4 debounce + 50). No SINGLE on release.
- Button0 pressed, button1 pressed 10 cycles later, both held 100 -> CHORD=0x3, LONG=0, SINGLE=0.
- Button0 bouncing 1/0 every 2 cycles for 40 cycles, then released -> LEVEL never 1, no events.
- With BUTTON_EVENT_IRQ_EN: IRQ_MASK=0x1, single click on button1 -> IRQ stays 0. Click on button0 -> IRQ=1. W1C of SINGLE -> IRQ=0 next cycle.
